age_buffer_2r2w: RTL and testbench
==================================

AGE_BUFFER_2R2W -- requirements
Module: age_buffer_2r2w

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 248: payload width per entry.
REQ-002 SHALL have parameter CONDITION_WIDTH, default 2: readiness condition bits per entry.
REQ-003 SHALL have parameter DEPTH, default 16: entry count, minimum 4.
REQ-004 SHALL have parameter ROBID_WIDTH, default 7: ROB id width, MSB is the wrap bit.
REQ-005 SHALL have parameter ROBID_LSB, default 241: payload bit where the ROB id field starts.
REQ-006 SHALL have ports; clock and reset are first:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enq_valid  in  2  per-port enqueue request.
- enq_ready  out  2  per-port accept.
- enq_data  in  2xDATA_WIDTH  payload.
- enq_condition  in  2xCONDITION_WIDTH  initial condition.
- deq_valid  out  2  port0 = oldest ready; port1 = second-oldest ready.
- deq_ready  in  2  consumer accept.
- deq_data  out  2xDATA_WIDTH  payload.
- deq_condition  out  2xCONDITION_WIDTH  condition.
- deq_index  out  2x$clog2(DEPTH)  slot index.
- update_valid  in  1  condition broadcast.
- update_robid  in  ROBID_WIDTH  target ROB id.
- update_mask  in  CONDITION_WIDTH  bits to overwrite.
- update_in  in  CONDITION_WIDTH  new bit values.
- flush_valid  in  1  squash request.
- flush_robid  in  ROBID_WIDTH  squash boundary.
- count  out  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-007 SHALL treat an entry as ready when it is valid and all of its condition bits are 1.
REQ-008 SHALL keep an age matrix: age[i][j]=1 means entry i is older than entry j; a row and its column clear when the entry is freed.
REQ-009 SHALL drive enq_ready[0] when the free count is at least 1 and enq_ready[1] when the free count is at least 2; both are 0 while flush_valid is 1.
REQ-010 SHALL write port 0 to the lowest free slot and port 1 to the next free slot. Either port may fire alone. When both fire, port 0 is older than port 1. Every new entry is younger than all existing entries.
REQ-011 SHALL select deq port 0 as the oldest ready entry and deq port 1 as the oldest ready entry excluding the port-0 selection. Selection is combinational from registered state, giving zero-cycle latency.
REQ-012 SHALL allow deq port 1 to fire only when deq port 0 fires in the same cycle. Each handshake frees its slot at the next edge.
REQ-013 SHALL make freed slots available for enqueue no earlier than the cycle after they are freed.
REQ-014 SHALL, on update_valid, apply condition <= (condition & ~update_mask) | (update_in & update_mask) to every valid entry whose ROB id field equals update_robid. The result is registered.
REQ-015 SHALL, on flush_valid, invalidate every entry strictly younger than flush_robid:
- younger = (E.wrap XOR F.wrap) XOR (E.idx > F.idx).
- the entry equal to flush_robid is kept.
REQ-016 SHALL force deq_valid to 00 and ignore enq_valid in any cycle with flush_valid=1. Flush has priority over update.
REQ-017 SHALL, for an update targeting an entry being dequeued in the same cycle, discard the update.
REQ-018 SHALL keep count equal to the number of valid entries, registered. DEPTH full means enq_ready=00; empty means deq_valid=00.
REQ-019 SHALL drive deq_data, deq_condition and deq_index to 0 whenever the corresponding deq_valid is 0.

Reset
REQ-020 SHALL, on reset assertion, immediately and asynchronously:
- clear all valid bits, the age matrix and count;
- set enq_ready=11 and deq_valid=00.
REQ-021 SHALL discard any in-flight handshake when reset asserts mid-operation, and SHALL accept enqueues on the first edge after reset deasserts.

Configuration
REQ-022 SHALL support macro AGE_BUFFER_WAKEUP_BYPASS_EN.
- Defined: the post-update condition (REQ-014) is used for readiness in the same cycle, so a matching entry may dequeue in the update cycle with the updated deq_condition.
- Undefined: readiness uses only the registered condition, and an updated entry becomes eligible one cycle later.

Verification
REQ-023 SHALL cover dual enqueue: empty buffer, enqueue A (cond 11) on port 0 and B (cond 11) on port 1 -> next cycle deq_valid=11, port 0=A, port 1=B, count=2.
REQ-024 SHALL cover age order across slots: enqueue C at slot 0 and D at slot 1, dequeue C, enqueue E into slot 0, all conditions 11 -> port 0=D, port 1=E.
REQ-025 SHALL cover wakeup: entry robid 0x05 with cond 01, update robid 0x05 mask 10 in 10 -> cond 11. Dequeue occurs the same cycle with the macro defined, the next cycle without it.
REQ-026 SHALL cover wrap flush: entries robid 0x7E, 0x7F, 0x00, 0x01; flush_robid 0x7F -> 0x00 and 0x01 invalidated, count=2, deq and enq blocked during the flush cycle.
REQ-027 SHALL cover full buffer: fill DEPTH entries -> enq_ready=00; dequeue two -> enq_ready=11 the cycle after the handshake, not before.
REQ-028 SHALL cover reset mid-operation: assert reset with 5 valid entries and deq_ready=11 -> count=0 and deq_valid=00 immediately, with no dequeue completed.

Source files
------------

// File: rtl/age_buffer_2r2w.sv
// Two-enqueue / two-dequeue age-ordered issue buffer with condition wakeup and ROB-id flush.
// Optional macro AGE_BUFFER_WAKEUP_BYPASS_EN lets an update make an entry ready in the same cycle.
module age_buffer_2r2w #(
    parameter int DATA_WIDTH      = 248,
    parameter int CONDITION_WIDTH = 2,
    parameter int DEPTH           = 16,
    parameter int ROBID_WIDTH     = 7,
    parameter int ROBID_LSB       = 241
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [1:0]                             enq_valid,
    output logic [1:0]                             enq_ready,
    input  logic [1:0][DATA_WIDTH-1:0]             enq_data,
    input  logic [1:0][CONDITION_WIDTH-1:0]        enq_condition,
    output logic [1:0]                             deq_valid,
    input  logic [1:0]                             deq_ready,
    output logic [1:0][DATA_WIDTH-1:0]             deq_data,
    output logic [1:0][CONDITION_WIDTH-1:0]        deq_condition,
    output logic [1:0][$clog2(DEPTH)-1:0]          deq_index,
    input  logic                                   update_valid,
    input  logic [ROBID_WIDTH-1:0]                 update_robid,
    input  logic [CONDITION_WIDTH-1:0]             update_mask,
    input  logic [CONDITION_WIDTH-1:0]             update_in,
    input  logic                                   flush_valid,
    input  logic [ROBID_WIDTH-1:0]                 flush_robid,
    output logic [$clog2(DEPTH):0]                 count
);
    localparam int IW   = $clog2(DEPTH);
    localparam int CNTW = IW + 1;
    localparam int RW   = ROBID_WIDTH;

    logic [DEPTH-1:0]                       valid_q, valid_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]       data_q, data_d;
    logic [DEPTH-1:0][CONDITION_WIDTH-1:0]  cond_q, cond_d, cond_upd, cond_eff;
    logic [DEPTH-1:0][DEPTH-1:0]            age_q, age_d;
    logic [CNTW-1:0]                        count_q, count_d;

    logic [DEPTH-1:0] upd_hit, flush_kill, rdy0, rdy1, sel0, sel1;
    logic [DEPTH-1:0] freed, keep, enq_oh0, enq_oh1;
    logic [IW-1:0]    idx0, idx1, slot0, slot1;
    logic             enq_fire0, enq_fire1, deq_fire0, deq_fire1;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [RW-1:0]    rid;
        logic [DEPTH-1:0] col;
        for (genvar h = 0; h < DEPTH; h++) begin : g_col
            assign col[h] = age_q[h][g];
        end
        assign rid         = data_q[g][ROBID_LSB +: RW];
        assign upd_hit[g]  = update_valid & ~flush_valid & valid_q[g] & (rid == update_robid);
        assign cond_upd[g] = upd_hit[g] ? ((cond_q[g] & ~update_mask) | (update_in & update_mask))
                                        : cond_q[g];
        // Wrap bits differing flips the sense of the index compare.
        assign flush_kill[g] = flush_valid & valid_q[g] &
                               ((rid[RW-1] ^ flush_robid[RW-1]) ^ (rid[RW-2:0] > flush_robid[RW-2:0]));
        assign rdy0[g] = valid_q[g] & (&cond_eff[g]);
        assign sel0[g] = rdy0[g] & ~|(rdy0 & col);
        assign rdy1[g] = rdy0[g] & ~sel0[g];
        assign sel1[g] = rdy1[g] & ~|(rdy1 & col);
    end

`ifdef AGE_BUFFER_WAKEUP_BYPASS_EN
    assign cond_eff = cond_upd;
`else
    assign cond_eff = cond_q;
`endif

    always_comb begin
        idx0 = '0;
        idx1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel0[i]) idx0 = IW'(i);
            if (sel1[i]) idx1 = IW'(i);
        end
    end

    assign deq_valid[0] = ~flush_valid & (|sel0);
    assign deq_valid[1] = ~flush_valid & (|sel1);

    for (genvar p = 0; p < 2; p++) begin : g_deq
        logic [IW-1:0] ix;
        assign ix = (p == 0) ? idx0 : idx1;
        assign deq_data[p]      = deq_valid[p] ? data_q[ix]   : '0;
        assign deq_condition[p] = deq_valid[p] ? cond_eff[ix] : '0;
        assign deq_index[p]     = deq_valid[p] ? ix           : '0;
    end

    assign deq_fire0 = deq_valid[0] & deq_ready[0];
    assign deq_fire1 = deq_valid[1] & deq_ready[1] & deq_fire0;
    assign freed     = ({DEPTH{deq_fire0}} & sel0) | ({DEPTH{deq_fire1}} & sel1);
    assign keep      = valid_q & ~freed & ~flush_kill;

    // Free space comes from registered state, so slots freed this cycle stay unavailable.
    assign enq_ready[0] = ~flush_valid & (count_q <  CNTW'(DEPTH));
    assign enq_ready[1] = ~flush_valid & (count_q <= CNTW'(DEPTH - 2));
    assign enq_fire0    = enq_valid[0] & enq_ready[0];
    assign enq_fire1    = enq_valid[1] & enq_ready[1];

    always_comb begin
        logic f0, f1;
        f0      = 1'b0;
        f1      = 1'b0;
        slot0   = '0;
        slot1   = '0;
        enq_oh0 = '0;
        enq_oh1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i]) begin
                if (!f0) begin
                    slot0 = IW'(i);
                    f0    = 1'b1;
                end else if (!f1) begin
                    slot1 = IW'(i);
                    f1    = 1'b1;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            enq_oh0[i] = enq_fire0 & (slot0 == IW'(i));
            enq_oh1[i] = enq_fire1 & (slot1 == IW'(i));
        end
    end

    always_comb begin
        valid_d = keep | enq_oh0 | enq_oh1;
        data_d  = data_q;
        cond_d  = cond_q;
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (enq_oh0[i]) begin
                data_d[i] = enq_data[0];
                cond_d[i] = enq_condition[0];
            end else if (enq_oh1[i]) begin
                data_d[i] = enq_data[1];
                cond_d[i] = enq_condition[1];
            end else if (!freed[i]) begin
                cond_d[i] = cond_upd[i];
            end
            count_d = count_d + CNTW'(valid_d[i]);
        end
    end

    // New entries are younger than every survivor; port 0 is older than port 1.
    always_comb begin
        age_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (enq_oh0[j] | enq_oh1[j])
                    age_d[i][j] = keep[i] | (enq_oh0[i] & enq_oh1[j]);
                else if (enq_oh0[i] | enq_oh1[i])
                    age_d[i][j] = 1'b0;
                else
                    age_d[i][j] = age_q[i][j] & keep[i] & keep[j];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
            cond_q  <= '0;
            age_q   <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cond_q  <= cond_d;
            age_q   <= age_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: tb/tb_age_buffer_2r2w.sv
// Directed bench for age_buffer_2r2w: vector table plus full-buffer and reset-mid-operation sequences.
module tb_age_buffer_2r2w;
    logic                  clock = 1'b0;
    logic                  reset;
    logic [1:0]            enq_valid, enq_ready, deq_valid, deq_ready;
    logic [1:0][247:0]     enq_data, deq_data;
    logic [1:0][1:0]       enq_condition, deq_condition;
    logic [1:0][3:0]       deq_index;
    logic                  update_valid, flush_valid;
    logic [6:0]            update_robid, flush_robid;
    logic [1:0]            update_mask, update_in;
    logic [4:0]            count;

    int checks = 0;
    int errors = 0;

    age_buffer_2r2w dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data), .enq_condition(enq_condition),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data), .deq_condition(deq_condition),
        .deq_index(deq_index),
        .update_valid(update_valid), .update_robid(update_robid), .update_mask(update_mask), .update_in(update_in),
        .flush_valid(flush_valid), .flush_robid(flush_robid), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] ev; logic [6:0] r0, r1; logic [1:0] c0, c1; logic [1:0] dr;
        logic uv; logic [6:0] ur; logic [1:0] um, ui; logic fv; logic [6:0] fr;
        logic [1:0] xdv; logic [6:0] xr0; logic [3:0] xi0; logic [1:0] xc0;
        logic [6:0] xr1; logic [3:0] xi1; logic [4:0] xcnt; logic [1:0] xer;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [247:0] mk(input logic [6:0] r);
        logic [240:0] body;
        body = 241'({r, 8'hA5, r});
        return {r, body};
    endfunction

    function automatic vec_t V(
        input logic [1:0] ev, input logic [6:0] r0, input logic [6:0] r1,
        input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] dr,
        input logic uv, input logic [6:0] ur, input logic [1:0] um, input logic [1:0] ui,
        input logic fv, input logic [6:0] fr,
        input logic [1:0] xdv, input logic [6:0] xr0, input logic [3:0] xi0, input logic [1:0] xc0,
        input logic [6:0] xr1, input logic [3:0] xi1, input logic [4:0] xcnt, input logic [1:0] xer);
        vec_t v;
        v.ev = ev; v.r0 = r0; v.r1 = r1; v.c0 = c0; v.c1 = c1; v.dr = dr;
        v.uv = uv; v.ur = ur; v.um = um; v.ui = ui; v.fv = fv; v.fr = fr;
        v.xdv = xdv; v.xr0 = xr0; v.xi0 = xi0; v.xc0 = xc0;
        v.xr1 = xr1; v.xi1 = xi1; v.xcnt = xcnt; v.xer = xer;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        enq_valid = '0; enq_data = '0; enq_condition = '0; deq_ready = '0;
        update_valid = 1'b0; update_robid = '0; update_mask = '0; update_in = '0;
        flush_valid = 1'b0; flush_robid = '0;
    endtask

    task automatic drive(input vec_t v);
        enq_valid = v.ev; enq_data[0] = mk(v.r0); enq_data[1] = mk(v.r1);
        enq_condition[0] = v.c0; enq_condition[1] = v.c1; deq_ready = v.dr;
        update_valid = v.uv; update_robid = v.ur; update_mask = v.um; update_in = v.ui;
        flush_valid = v.fv; flush_robid = v.fr;
    endtask

    task automatic check_vec(input int k, input vec_t v);
        chk($sformatf("v%0d deq_valid", k), 256'(deq_valid), 256'(v.xdv));
        chk($sformatf("v%0d count", k), 256'(count), 256'(v.xcnt));
        chk($sformatf("v%0d enq_ready", k), 256'(enq_ready), 256'(v.xer));
        if (v.xdv[0]) begin
            chk($sformatf("v%0d data0", k), 256'(deq_data[0]), 256'(mk(v.xr0)));
            chk($sformatf("v%0d index0", k), 256'(deq_index[0]), 256'(v.xi0));
            chk($sformatf("v%0d cond0", k), 256'(deq_condition[0]), 256'(v.xc0));
        end else begin
            chk($sformatf("v%0d zero0", k), 256'({deq_data[0], deq_index[0], deq_condition[0]}), 256'(0));
        end
        if (v.xdv[1]) begin
            chk($sformatf("v%0d data1", k), 256'(deq_data[1]), 256'(mk(v.xr1)));
            chk($sformatf("v%0d index1", k), 256'(deq_index[1]), 256'(v.xi1));
            chk($sformatf("v%0d cond1", k), 256'(deq_condition[1]), 256'(2'b11));
        end else begin
            chk($sformatf("v%0d zero1", k), 256'({deq_data[1], deq_index[1], deq_condition[1]}), 256'(0));
        end
    endtask

    initial begin
        // V(ev,r0,r1,c0,c1,dr, uv,ur,um,ui, fv,fr, xdv,xr0,xi0,xc0,xr1,xi1,xcnt,xer)
        tbl.push_back(V(0,0,0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0,3));
        tbl.push_back(V(3,'h10,'h11,3,3,0, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0,3));
        tbl.push_back(V(0,0,0,0,0,0, 0,0,0,0, 0,0, 3,'h10,0,3,'h11,1, 2,3));
        tbl.push_back(V(0,0,0,0,0,3, 0,0,0,0, 0,0, 3,'h10,0,3,'h11,1, 2,3));
        tbl.push_back(V(0,0,0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0,3));
        tbl.push_back(V(3,'h20,'h21,3,3,0, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0,3));
        tbl.push_back(V(0,0,0,0,0,1, 0,0,0,0, 0,0, 3,'h20,0,3,'h21,1, 2,3));
        tbl.push_back(V(1,'h22,0,3,0,0, 0,0,0,0, 0,0, 1,'h21,1,3,0,0, 1,3));
        tbl.push_back(V(0,0,0,0,0,3, 0,0,0,0, 0,0, 3,'h21,1,3,'h22,0, 2,3));
        tbl.push_back(V(3,'h30,'h31,3,3,0, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0,3));
        tbl.push_back(V(0,0,0,0,0,2, 0,0,0,0, 0,0, 3,'h30,0,3,'h31,1, 2,3));
        tbl.push_back(V(0,0,0,0,0,3, 0,0,0,0, 0,0, 3,'h30,0,3,'h31,1, 2,3));
        tbl.push_back(V(3,'h7E,'h7F,3,3,0, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0,3));
        tbl.push_back(V(3,'h00,'h01,3,3,0, 0,0,0,0, 0,0, 3,'h7E,0,3,'h7F,1, 2,3));
        tbl.push_back(V(3,'h40,'h41,3,3,3, 0,0,0,0, 1,'h7F, 0,0,0,0,0,0, 4,0));
        tbl.push_back(V(0,0,0,0,0,0, 0,0,0,0, 0,0, 3,'h7E,0,3,'h7F,1, 2,3));
        tbl.push_back(V(0,0,0,0,0,3, 0,0,0,0, 0,0, 3,'h7E,0,3,'h7F,1, 2,3));
        tbl.push_back(V(1,'h05,0,1,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0,3));
`ifdef AGE_BUFFER_WAKEUP_BYPASS_EN
        tbl.push_back(V(0,0,0,0,0,1, 1,'h05,2,2, 0,0, 1,'h05,0,3,0,0, 1,3));
        tbl.push_back(V(0,0,0,0,0,1, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0,3));
`else
        tbl.push_back(V(0,0,0,0,0,1, 1,'h05,2,2, 0,0, 0,0,0,0,0,0, 1,3));
        tbl.push_back(V(0,0,0,0,0,1, 0,0,0,0, 0,0, 1,'h05,0,3,0,0, 1,3));
`endif
        tbl.push_back(V(0,0,0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0,3));
        tbl.push_back(V(1,'h06,0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0,3));
        tbl.push_back(V(0,0,0,0,0,0, 1,'h07,3,3, 0,0, 0,0,0,0,0,0, 1,3));
        tbl.push_back(V(0,0,0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0, 1,3));
        tbl.push_back(V(0,0,0,0,0,0, 1,'h06,1,1, 0,0, 0,0,0,0,0,0, 1,3));
        tbl.push_back(V(0,0,0,0,0,0, 1,'h06,2,2, 1,'h06, 0,0,0,0,0,0, 1,0));
        tbl.push_back(V(0,0,0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0, 1,3));
`ifdef AGE_BUFFER_WAKEUP_BYPASS_EN
        tbl.push_back(V(0,0,0,0,0,0, 1,'h06,2,2, 0,0, 1,'h06,0,3,0,0, 1,3));
`else
        tbl.push_back(V(0,0,0,0,0,0, 1,'h06,2,2, 0,0, 0,0,0,0,0,0, 1,3));
`endif
        tbl.push_back(V(0,0,0,0,0,1, 0,0,0,0, 0,0, 1,'h06,0,3,0,0, 1,3));
        tbl.push_back(V(0,0,0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0,3));

        idle_in();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset count", 256'(count), 256'(0));
        chk("reset deq_valid", 256'(deq_valid), 256'(0));
        chk("reset enq_ready", 256'(enq_ready), 256'(3));
        reset = 1'b0;

        foreach (tbl[k]) begin
            drive(tbl[k]);
            @(negedge clock);
            check_vec(k, tbl[k]);
            @(posedge clock);
            #1;
        end
        idle_in();

        // Fill all 16 slots, then a dequeue frees space only from the next cycle.
        for (int k = 0; k < 8; k++) begin
            idle_in();
            enq_valid = 2'b11;
            enq_data[0] = mk(7'('h50 + 2 * k));
            enq_data[1] = mk(7'('h51 + 2 * k));
            enq_condition[0] = 2'b11;
            enq_condition[1] = 2'b11;
            @(posedge clock);
            #1;
        end
        idle_in();
        @(negedge clock);
        chk("full count", 256'(count), 256'(16));
        chk("full enq_ready", 256'(enq_ready), 256'(0));
        chk("full data0", 256'(deq_data[0]), 256'(mk('h50)));
        chk("full data1", 256'(deq_data[1]), 256'(mk('h51)));
        deq_ready = 2'b11;
        enq_valid = 2'b11;
        enq_data[0] = mk('h7A);
        enq_data[1] = mk('h7B);
        #1;
        chk("full hs enq_ready", 256'(enq_ready), 256'(0));
        chk("full hs deq_valid", 256'(deq_valid), 256'(3));
        @(posedge clock);
        #1;
        idle_in();
        @(negedge clock);
        chk("after hs count", 256'(count), 256'(14));
        chk("after hs enq_ready", 256'(enq_ready), 256'(3));
        for (int k = 1; k < 8; k++) begin
            deq_ready = 2'b11;
            #1;
            chk($sformatf("drain%0d data0", k), 256'(deq_data[0]), 256'(mk(7'('h50 + 2 * k))));
            chk($sformatf("drain%0d data1", k), 256'(deq_data[1]), 256'(mk(7'('h51 + 2 * k))));
            @(posedge clock);
            #1;
            idle_in();
            @(negedge clock);
        end
        chk("drained count", 256'(count), 256'(0));

        // Reset lands while two dequeues are being offered.
        @(posedge clock);
        #1;
        enq_valid = 2'b11; enq_data[0] = mk('h60); enq_data[1] = mk('h61); enq_condition = '1;
        @(posedge clock);
        #1;
        enq_data[0] = mk('h62); enq_data[1] = mk('h63);
        @(posedge clock);
        #1;
        enq_valid = 2'b01; enq_data[0] = mk('h64);
        @(posedge clock);
        #1;
        idle_in();
        deq_ready = 2'b11;
        @(negedge clock);
        chk("pre-rst count", 256'(count), 256'(5));
        chk("pre-rst deq_valid", 256'(deq_valid), 256'(3));
        #2;
        reset = 1'b1;
        #1;
        chk("rst count", 256'(count), 256'(0));
        chk("rst deq_valid", 256'(deq_valid), 256'(0));
        chk("rst enq_ready", 256'(enq_ready), 256'(3));
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_in();
        enq_valid = 2'b01; enq_data[0] = mk('h70); enq_condition[0] = 2'b11;
        @(negedge clock);
        chk("post-rst count", 256'(count), 256'(0));
        @(posedge clock);
        #1;
        idle_in();
        @(negedge clock);
        chk("first enq count", 256'(count), 256'(1));
        chk("first enq deq_valid", 256'(deq_valid), 256'(1));
        chk("first enq data0", 256'(deq_data[0]), 256'(mk('h70)));
        deq_ready = 2'b01;
        @(posedge clock);
        #1;
        idle_in();
        @(negedge clock);
        chk("final count", 256'(count), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
